// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller: FSM states,
// door phases, door segment patterns and the 7-segment floor digit table.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DOOR,
        ST_MOVE
    } state_e;

    typedef enum logic [2:0] {
        PH_OPEN1,
        PH_OPEN2,
        PH_HOLD,
        PH_SHUT2,
        PH_SHUT1,
        PH_CLOSE
    } door_ph_e;

    localparam logic [5:0] DOOR_CLOSE = 6'b111111;
    localparam logic [5:0] DOOR_OPEN1 = 6'b110011;
    localparam logic [5:0] DOOR_OPEN2 = 6'b100001;
    localparam logic [5:0] DOOR_OPEN3 = 6'b000000;

    // Floor f is shown as digit f+1, segments a..g MSB first.
    function automatic logic [6:0] seg_digit(input logic [2:0] f);
        case (f)
            3'd0:    return 7'b0110000;
            3'd1:    return 7'b1101101;
            3'd2:    return 7'b1111001;
            3'd3:    return 7'b0110011;
            3'd4:    return 7'b1011011;
            3'd5:    return 7'b1011111;
            3'd6:    return 7'b1110000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [5:0] door_pattern(input door_ph_e ph);
        case (ph)
            PH_OPEN1, PH_SHUT1: return DOOR_OPEN1;
            PH_OPEN2, PH_SHUT2: return DOOR_OPEN2;
            PH_HOLD:            return DOOR_OPEN3;
            default:            return DOOR_CLOSE;
        endcase
    endfunction

endpackage

// File: rtl/elevator_req_bank.sv
// Sticky request register per floor with clear/consume at one evaluation floor,
// plus here/ahead/behind reductions relative to that floor and a direction.
module elevator_req_bank #(
    parameter int NUM_FLOORS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] fb_n,
    input  logic [NUM_FLOORS-1:0] call_n,
    input  logic [2:0]            eval_floor,
    input  logic                  dir,
    input  logic                  clr,
    input  logic                  consume,
    output logic                  here,
    output logic                  ahead,
    output logic                  behind
);

    logic [NUM_FLOORS-1:0] req_q, req_d;

    always_comb begin
        here   = 1'b0;
        ahead  = 1'b0;
        behind = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (3'(i) == eval_floor)
                here = req_q[i];
            else if ((3'(i) > eval_floor) == dir)
                ahead = ahead | req_q[i];
            else
                behind = behind | req_q[i];
        end
    end

    // Clearing the served floor wins over a press arriving on the same edge.
    always_comb begin
        req_d = req_q | ~fb_n | ~call_n;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (3'(i) == eval_floor) begin
                if (consume) req_d[i] = req_q[i];
                if (clr)     req_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) req_q <= '0;
        else       req_q <= req_d;
    end

endmodule

// File: rtl/elevator_ctrl.sv
// N-floor elevator car controller: SCAN service policy, door phase sequencing
// and floor indicator. ELEVATOR_DOOR_REOPEN_EN enables door reopen while closing.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_HOLD     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] fb_n,
    input  logic [NUM_FLOORS-1:0] call_n,
    output logic [5:0]            door,
    output logic [6:0]            fi,
    output logic                  ud,
    output logic [2:0]            floor,
    output logic                  busy
);

    localparam logic [2:0] TOP_FLOOR = 3'(NUM_FLOORS - 1);
    localparam logic [3:0] TRAV_LAST = 4'(TRAVEL_CYCLES - 1);
    localparam logic [2:0] HOLD_LAST = 3'(DOOR_HOLD - 1);

    state_e     state_q, state_d;
    door_ph_e   phase_q, phase_d;
    logic [2:0] hold_q, hold_d;
    logic [3:0] trav_q, trav_d;
    logic [2:0] floor_q, floor_d;
    logic       ud_q, ud_d;
    logic [5:0] door_q, door_d;
    logic [6:0] fi_q, fi_d;
    logic       busy_q, busy_d;

    logic [2:0] nxt_floor, eval_floor;
    logic       arrive, here, ahead, behind, clr, consume, reopen;

    assign nxt_floor  = ud_q ? floor_q + 3'd1 : floor_q - 3'd1;
    assign arrive     = (state_q == ST_MOVE) && (trav_q == TRAV_LAST);
    // On the arrival edge decisions are made for the floor being entered.
    assign eval_floor = arrive ? nxt_floor : floor_q;

`ifdef ELEVATOR_DOOR_REOPEN_EN
    always_comb begin
        reopen = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (3'(i) == floor_q) reopen = ~fb_n[i] | ~call_n[i];
    end
`else
    assign reopen = 1'b0;
`endif

    elevator_req_bank #(.NUM_FLOORS(NUM_FLOORS)) u_req (
        .clk        (clk),
        .reset      (reset),
        .fb_n       (fb_n),
        .call_n     (call_n),
        .eval_floor (eval_floor),
        .dir        (ud_q),
        .clr        (clr),
        .consume    (consume),
        .here       (here),
        .ahead      (ahead),
        .behind     (behind)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        trav_d  = trav_q;
        floor_d = floor_q;
        ud_d    = ud_q;
        clr     = 1'b0;
        consume = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (here) begin
                    state_d = ST_DOOR;
                    phase_d = PH_OPEN1;
                    clr     = 1'b1;
                end else if (ahead) begin
                    state_d = ST_MOVE;
                    trav_d  = '0;
                end else if (behind) begin
                    state_d = ST_MOVE;
                    trav_d  = '0;
                    ud_d    = ~ud_q;
                end
                if (state_d != ST_IDLE) begin
                    if (floor_q == 3'd0)           ud_d = 1'b1;
                    else if (floor_q == TOP_FLOOR) ud_d = 1'b0;
                end
            end
            ST_MOVE: begin
                if (arrive) begin
                    floor_d = nxt_floor;
                    trav_d  = '0;
                    if (here) begin
                        state_d = ST_DOOR;
                        phase_d = PH_OPEN1;
                        clr     = 1'b1;
                    end else if (!ahead) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    trav_d = trav_q + 4'd1;
                end
            end
            ST_DOOR: begin
                consume = 1'b1;
                case (phase_q)
                    PH_OPEN1: phase_d = PH_OPEN2;
                    PH_OPEN2: begin
                        phase_d = PH_HOLD;
                        hold_d  = '0;
                    end
                    PH_HOLD: begin
                        if (hold_q == HOLD_LAST) phase_d = PH_SHUT2;
                        else                     hold_d  = hold_q + 3'd1;
                    end
                    PH_SHUT2: begin
                        phase_d = reopen ? PH_HOLD : PH_SHUT1;
                        hold_d  = '0;
                    end
                    PH_SHUT1: begin
                        phase_d = reopen ? PH_HOLD : PH_CLOSE;
                        hold_d  = '0;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
        door_d = (state_d == ST_DOOR) ? door_pattern(phase_d) : DOOR_CLOSE;
        fi_d   = seg_digit(floor_d);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_OPEN1;
            hold_q  <= '0;
            trav_q  <= '0;
            floor_q <= '0;
            ud_q    <= 1'b1;
            door_q  <= DOOR_CLOSE;
            fi_q    <= seg_digit(3'd0);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            trav_q  <= trav_d;
            floor_q <= floor_d;
            ud_q    <= ud_d;
            door_q  <= door_d;
            fi_q    <= fi_d;
            busy_q  <= busy_d;
        end
    end

    assign door  = door_q;
    assign fi    = fi_q;
    assign ud    = ud_q;
    assign floor = floor_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed scenarios plus randomized presses checked
// against a cycle-level behavioural model of the service rules.
module tb_elevator_ctrl;

    localparam int NF = 8;
    localparam int TC = 4;
    localparam int DH = 2;
`ifdef ELEVATOR_DOOR_REOPEN_EN
    localparam bit REOPEN = 1'b1;
`else
    localparam bit REOPEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NF-1:0] fb_n = '1;
    logic [NF-1:0] call_n = '1;
    logic [5:0]    door;
    logic [6:0]    fi;
    logic          ud;
    logic [2:0]    floor;
    logic          busy;

    int n_chk = 0;
    int n_fail = 0;

    logic [6:0] DIGITS [8] = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111};

    elevator_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_HOLD(DH)) dut (
        .clk    (clk),
        .reset  (reset),
        .fb_n   (fb_n),
        .call_n (call_n),
        .door   (door),
        .fi     (fi),
        .ud     (ud),
        .floor  (floor),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 door (m_t = door tick), 2 move (m_t = cycles travelled)
    int            m_mode, m_floor, m_t;
    bit            m_up;
    logic [NF-1:0] m_req;

    task automatic model_reset();
        m_mode = 0; m_floor = 0; m_t = 0; m_up = 1'b1; m_req = '0;
    endtask

    function automatic bit any_dir(logic [NF-1:0] v, int f, bit up);
        for (int i = 0; i < NF; i++)
            if (v[i] && (up ? (i > f) : (i < f))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [5:0] m_door();
        if (m_mode != 1) return 6'b111111;
        if (m_t == 0 || m_t == DH + 3) return 6'b110011;
        if (m_t == 1 || m_t == DH + 2) return 6'b100001;
        if (m_t >= 2 && m_t < DH + 2) return 6'b000000;
        return 6'b111111;
    endfunction

    task automatic model_step(input logic [NF-1:0] p);
        logic [NF-1:0] old;
        old = m_req;
        m_req = m_req | p;
        case (m_mode)
            0: begin
                if (old[m_floor]) begin
                    m_mode = 1; m_t = 0; m_req[m_floor] = 1'b0;
                end else if (any_dir(old, m_floor, m_up)) begin
                    m_mode = 2; m_t = 0;
                end else if (any_dir(old, m_floor, !m_up)) begin
                    m_mode = 2; m_t = 0; m_up = !m_up;
                end
                if (m_mode != 0) begin
                    if (m_floor == 0) m_up = 1'b1;
                    else if (m_floor == NF - 1) m_up = 1'b0;
                end
            end
            1: begin
                m_req[m_floor] = old[m_floor];
                if (REOPEN && p[m_floor] && (m_t == DH + 2 || m_t == DH + 3)) m_t = 2;
                else begin
                    m_t++;
                    if (m_t == DH + 5) m_mode = 0;
                end
            end
            default: begin
                m_t++;
                if (m_t == TC) begin
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    m_t = 0;
                    if (old[m_floor]) begin
                        m_mode = 1; m_req[m_floor] = 1'b0;
                    end else if (!any_dir(old, m_floor, m_up)) m_mode = 0;
                end
            end
        endcase
    endtask

    task automatic step(input logic [NF-1:0] fbp, input logic [NF-1:0] cp);
        fb_n = ~fbp;
        call_n = ~cp;
        @(posedge clk);
        if (!reset) model_step(fbp | cp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        fb_n = '1; call_n = '1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 200) begin step('0, '0); n++; end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wait_idle: busy=%b after %0d cycles, required 0", tag, busy, n);
        end
    endtask

    task automatic wait_door(input string tag);
        int n = 0;
        while (door !== 6'b110011 && n < 200) begin step('0, '0); n++; end
        n_chk++;
        if (door !== 6'b110011) begin
            n_fail++;
            $display("FAIL %s wait_door: door=%b after %0d cycles, required 110011", tag, door, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        #1;
        n_chk++;
        if ({floor, ud, door, fi, busy} !== {3'd0, 1'b1, 6'b111111, 7'b0110000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got floor=%0d ud=%b door=%b fi=%b busy=%b", floor, ud, door, fi, busy);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step('0, '0);
            n_chk++;
            if ({floor, door, fi, busy} !== {3'd0, 6'b111111, 7'b0110000, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: got floor=%0d door=%b fi=%b busy=%b", i, floor, door, fi, busy);
            end
        end
    endtask

    task automatic test_door_seq();
        logic [5:0] exp_d [7] = '{6'b110011, 6'b100001, 6'b000000, 6'b000000,
                                  6'b100001, 6'b110011, 6'b111111};
        step('0, 8'h01);
        for (int i = 0; i < 7; i++) begin
            step('0, '0);
            n_chk++;
            if (door !== exp_d[i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL door_seq[%0d]: got door=%b busy=%b, required door=%b busy=1", i, door, busy, exp_d[i]);
            end
        end
        step('0, '0);
        n_chk++;
        if (busy !== 1'b0 || door !== 6'b111111) begin
            n_fail++;
            $display("FAIL door_seq_end: got busy=%b door=%b, required 0 111111", busy, door);
        end
    endtask

    task automatic test_travel();
        step(8'h04, '0);
        step('0, '0);
        n_chk++;
        if ({busy, ud, floor, door} !== {1'b1, 1'b1, 3'd0, 6'b111111}) begin
            n_fail++;
            $display("FAIL travel_start: got busy=%b ud=%b floor=%0d door=%b", busy, ud, floor, door);
        end
        repeat (3) step('0, '0);
        n_chk++;
        if (floor !== 3'd0) begin
            n_fail++;
            $display("FAIL travel_hold: got floor=%0d, required 0", floor);
        end
        step('0, '0);
        n_chk++;
        if (floor !== 3'd1 || fi !== 7'b1101101 || door !== 6'b111111) begin
            n_fail++;
            $display("FAIL travel_f1: got floor=%0d fi=%b door=%b", floor, fi, door);
        end
        repeat (4) step('0, '0);
        n_chk++;
        if (floor !== 3'd2 || fi !== 7'b1111001 || door !== 6'b110011) begin
            n_fail++;
            $display("FAIL travel_f2: got floor=%0d fi=%b door=%b, required 2 1111001 110011", floor, fi, door);
        end
        wait_idle("travel");
    endtask

    task automatic test_scan();
        do_reset();
        step(8'h02, '0);
        wait_door("scan_to1");
        wait_idle("scan_to1");
        n_chk++;
        if (floor !== 3'd1 || ud !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_setup: got floor=%0d ud=%b, required 1 1", floor, ud);
        end
        step(8'h05, '0);
        step('0, '0);
        n_chk++;
        if (ud !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_go_up: got ud=%b busy=%b, required 1 1", ud, busy);
        end
        wait_door("scan_up");
        n_chk++;
        if (floor !== 3'd2) begin
            n_fail++;
            $display("FAIL scan_first_stop: got floor=%0d, required 2", floor);
        end
        wait_idle("scan_up");
        step('0, '0);
        n_chk++;
        if (ud !== 1'b0 || busy !== 1'b1 || floor !== 3'd2) begin
            n_fail++;
            $display("FAIL scan_reverse: got ud=%b busy=%b floor=%0d, required 0 1 2", ud, busy, floor);
        end
        wait_door("scan_down");
        n_chk++;
        if (floor !== 3'd0 || ud !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_second_stop: got floor=%0d ud=%b, required 0 0", floor, ud);
        end
        wait_idle("scan_down");
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        step(8'h04, '0);
        step('0, '0);
        repeat (6) step('0, '0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_chk++;
        if ({floor, ud, door, fi, busy} !== {3'd0, 1'b1, 6'b111111, 7'b0110000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_move: got floor=%0d ud=%b door=%b fi=%b busy=%b", floor, ud, door, fi, busy);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) step('0, '0);
        n_chk++;
        if (busy !== 1'b0 || floor !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_req_cleared: got busy=%b floor=%0d, required 0 0", busy, floor);
        end
    endtask

    task automatic test_top_floor();
        int n = 0;
        do_reset();
        step(8'h80, '0);
        step('0, '0);
        while (floor !== 3'd7 && n < 100) begin step('0, '0); n++; end
        n_chk++;
        if (n != 7 * TC || fi !== 7'b1111111 || door !== 6'b110011) begin
            n_fail++;
            $display("FAIL top_arrive: got %0d cycles fi=%b door=%b, required %0d 1111111 110011", n, fi, door, 7 * TC);
        end
        repeat (5) step('0, '0);
        n_chk++;
        if (door !== 6'b110011) begin
            n_fail++;
            $display("FAIL top_closing: got door=%b, required 110011", door);
        end
        step(8'h80, '0);
        n_chk++;
        if (door !== (REOPEN ? 6'b000000 : 6'b111111)) begin
            n_fail++;
            $display("FAIL top_reopen: got door=%b, required %b", door, REOPEN ? 6'b000000 : 6'b111111);
        end
        wait_idle("top");
        repeat (3) step('0, '0);
        n_chk++;
        if (busy !== 1'b0 || floor !== 3'd7) begin
            n_fail++;
            $display("FAIL top_press_consumed: got busy=%b floor=%0d, required 0 7", busy, floor);
        end
    endtask

    task automatic test_random();
        logic [NF-1:0] fbp, cp;
        logic [17:0]   exp_v;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            fbp = ($urandom_range(0, 9) == 0) ? NF'($urandom) : '0;
            cp  = ($urandom_range(0, 11) == 0) ? NF'($urandom) : '0;
            step(fbp, cp);
            exp_v = {3'(m_floor), m_up, m_door(), DIGITS[m_floor], m_mode != 0};
            n_chk++;
            if ({floor, ud, door, fi, busy} !== exp_v) begin
                n_fail++;
                $display("FAIL random c%0d: got floor/ud/door/fi/busy=%h, required %h", i, {floor, ud, door, fi, busy}, exp_v);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_door_seq();
        test_travel();
        test_scan();
        test_reset_mid_move();
        test_top_floor();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
